// File: rtl/iibg_ctrl_23x23.sv
// ---------------------------------------------------------------------------
// iibg_ctrl_23x23
//
// Sequencer for the 23x23 integral-image window buffer.
//
// A window is 576 integral-image words (24x24, 21 bits each). The words are
// streamed from the integral-image generator straight into the window buffer.
// After that, each feature is evaluated as 8 rectangle reads. Each read puts
// four corner addresses on the buffer read port in four consecutive cycles.
// The eight packed rectangle results are then handed to the classifier.
// Between features the buffer's select/output state is cleared.
//
// Ports
//   iClk, iReset_n    clock, synchronous active-low reset
//   iStart            pulse, begin a new window (only honoured in IDLE)
//   iValid/iData      upstream integral-image word
//   oReady            upstream ready; a word moves when iValid & oReady
//   iFeat_valid       corner table entry valid
//   iCorners          {c3,c2,c1,c0}, 10-bit buffer addresses
//   iFeat_last        current feature is the last one of this window
//   oCorner_ack       pulse, the current iCorners has been consumed
//   oWin_valid        the 8 rectangle words are stable on the buffer outputs
//   iWin_ack          the classifier has taken them
//   oDone             pulse, the whole window is finished
//   oWrreq/oData_in   buffer write port (zero-latency pass-through)
//   oRdreq/oAddr_read buffer read port
//   oFull             buffer clear pulse
//   oRst              buffer write-pointer reset pulse
// ---------------------------------------------------------------------------
module iibg_ctrl_23x23 #(
    parameter int N_WORDS = 576,
    parameter int N_RECT  = 8,
    parameter int RD_GAP  = 7
) (
    input  logic        iClk,
    input  logic        iReset_n,
    input  logic        iStart,
    input  logic        iValid,
    input  logic [20:0] iData,
    output logic        oReady,
    input  logic        iFeat_valid,
    input  logic [39:0] iCorners,
    input  logic        iFeat_last,
    output logic        oCorner_ack,
    output logic        oWin_valid,
    input  logic        iWin_ack,
    output logic        oDone,
    output logic        oWrreq,
    output logic [20:0] oData_in,
    output logic        oRdreq,
    output logic [9:0]  oAddr_read,
    output logic        oFull,
    output logic        oRst
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_LOAD,
        ST_ISSUE,
        ST_WAIT,
        ST_HANDOFF,
        ST_CLEAR,
        ST_FIN
    } state_t;

    localparam logic [9:0] WR_LAST   = 10'(N_WORDS - 1);
    localparam logic [9:0] WR_END    = 10'(N_WORDS);
    localparam logic [3:0] GAP_SAT   = 4'(RD_GAP);
    localparam logic [3:0] RECT_LAST = 4'(N_RECT - 1);

    state_t      state_reg, state_next;
    logic [9:0]  wr_cnt_reg, wr_cnt_next;
    logic [3:0]  rect_cnt_reg, rect_cnt_next;
    // Cycles elapsed since the most recent c0 cycle, saturating at RD_GAP.
    logic [3:0]  gap_cnt_reg, gap_cnt_next;
    // Corner index of the rectangle being issued. 0 means no rectangle is
    // in flight (the next c0 may start); 1..3 are the c1..c3 cycles.
    logic [1:0]  phase_reg, phase_next;
    logic        feat_last_reg, feat_last_next;

    logic [9:0]  corner_w [4];
    logic        gap_ok;
    logic        load_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_corner
            assign corner_w[gi] = iCorners[gi*10 +: 10];
        end
    endgenerate

    assign gap_ok     = (gap_cnt_reg >= GAP_SAT);
    assign load_ready = (wr_cnt_reg < WR_END);

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state_reg     <= ST_IDLE;
            wr_cnt_reg    <= '0;
            rect_cnt_reg  <= '0;
            gap_cnt_reg   <= '0;
            phase_reg     <= '0;
            feat_last_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_cnt_reg    <= wr_cnt_next;
            rect_cnt_reg  <= rect_cnt_next;
            gap_cnt_reg   <= gap_cnt_next;
            phase_reg     <= phase_next;
            feat_last_reg <= feat_last_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        wr_cnt_next    = wr_cnt_reg;
        rect_cnt_next  = rect_cnt_reg;
        phase_next     = phase_reg;
        feat_last_next = feat_last_reg;
        // The gap counter free-runs up to its ceiling in every state, so the
        // first rectangle of any feature never has to wait.
        gap_cnt_next   = gap_ok ? GAP_SAT : gap_cnt_reg + 4'd1;

        oReady      = 1'b0;
        oCorner_ack = 1'b0;
        oWin_valid  = 1'b0;
        oDone       = 1'b0;
        oWrreq      = 1'b0;
        oData_in    = '0;
        oRdreq      = 1'b0;
        oAddr_read  = '0;
        oFull       = 1'b0;
        oRst        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (iStart) begin
                    state_next = ST_RST;
                end
            end

            ST_RST: begin
                oRst        = 1'b1;
                wr_cnt_next = '0;
                state_next  = ST_LOAD;
            end

            ST_LOAD: begin
                oReady = load_ready;
                // Write data is passed straight through in the transfer cycle.
                if (iValid && load_ready) begin
                    oWrreq      = 1'b1;
                    oData_in    = iData;
                    wr_cnt_next = wr_cnt_reg + 10'd1;
                    if (wr_cnt_reg == WR_LAST) begin
                        state_next = ST_ISSUE;
                    end
                end
            end

            ST_ISSUE: begin
                if (phase_reg == 2'd0) begin
                    if (iFeat_valid && gap_ok) begin
                        oRdreq       = 1'b1;
                        oAddr_read   = corner_w[0];
                        phase_next   = 2'd1;
                        // This c0 cycle counts as gap 0; the next cycle is 1.
                        gap_cnt_next = 4'd1;
                    end
                end else begin
                    // c1..c3 run unconditionally once c0 has been issued.
                    oAddr_read = corner_w[phase_reg];
                    if (phase_reg == 2'd3) begin
                        oCorner_ack    = 1'b1;
                        phase_next     = 2'd0;
                        feat_last_next = iFeat_last;
                        rect_cnt_next  = rect_cnt_reg + 4'd1;
                        if (rect_cnt_reg == RECT_LAST) begin
                            state_next = ST_WAIT;
                        end
                    end else begin
                        phase_next = phase_reg + 2'd1;
                    end
                end
            end

            ST_WAIT: begin
                // The last rectangle is packed once RD_GAP cycles have passed
                // since its c0.
                if (gap_ok) begin
                    state_next = ST_HANDOFF;
                end
            end

            ST_HANDOFF: begin
                oWin_valid = 1'b1;
                if (iWin_ack) begin
                    state_next = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                oFull         = 1'b1;
                rect_cnt_next = '0;
                state_next    = feat_last_reg ? ST_FIN : ST_ISSUE;
            end

            ST_FIN: begin
                oDone      = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iibg_ctrl_23x23.sv
// ---------------------------------------------------------------------------
// tb_iibg_ctrl_23x23
//
// Directed sequence of windows against the window-buffer sequencer. Upstream
// words and corner tables are random (except for the directed first window).
// Expectations come from the protocol rules: the written word stream must
// equal the offered stream, every rectangle shows c0..c3 with one read
// request, consecutive reads are RD_GAP apart, and handoff/clear/done pulses
// follow in fixed order.
// ---------------------------------------------------------------------------
module tb_iibg_ctrl_23x23;

    localparam int N_WORDS = 576;
    localparam int N_RECT  = 8;
    localparam int RD_GAP  = 7;

    logic        iClk = 1'b0;
    logic        iReset_n = 1'b0;
    logic        iStart = 1'b0;
    logic        iValid = 1'b0;
    logic [20:0] iData = '0;
    logic        iFeat_valid = 1'b0;
    logic [39:0] iCorners = '0;
    logic        iFeat_last = 1'b0;
    logic        iWin_ack = 1'b0;

    logic        oReady;
    logic        oCorner_ack;
    logic        oWin_valid;
    logic        oDone;
    logic        oWrreq;
    logic [20:0] oData_in;
    logic        oRdreq;
    logic [9:0]  oAddr_read;
    logic        oFull;
    logic        oRst;

    iibg_ctrl_23x23 dut (
        .iClk        (iClk),
        .iReset_n    (iReset_n),
        .iStart      (iStart),
        .iValid      (iValid),
        .iData       (iData),
        .oReady      (oReady),
        .iFeat_valid (iFeat_valid),
        .iCorners    (iCorners),
        .iFeat_last  (iFeat_last),
        .oCorner_ack (oCorner_ack),
        .oWin_valid  (oWin_valid),
        .iWin_ack    (iWin_ack),
        .oDone       (oDone),
        .oWrreq      (oWrreq),
        .oData_in    (oData_in),
        .oRdreq      (oRdreq),
        .oAddr_read  (oAddr_read),
        .oFull       (oFull),
        .oRst        (oRst)
    );

    always #5 iClk = ~iClk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge iClk) cyc <= cyc + 1;

    logic [38:0] outs_all;
    assign outs_all = {oReady, oCorner_ack, oWin_valid, oDone, oWrreq, oData_in,
                       oRdreq, oAddr_read, oFull, oRst};

    // Observation log, sampled mid-cycle.
    int n_rd = 0, n_full = 0, n_done = 0, n_rst = 0, n_overlap = 0, n_stray = 0;
    int addr_pos = 0;
    logic [20:0] wr_log [$];
    logic [20:0] exp_words [$];

    always @(negedge iClk) begin
        if (!iReset_n) begin
            addr_pos <= 0;
        end else begin
            if (oWrreq) wr_log.push_back(oData_in);
            if (oRdreq) n_rd <= n_rd + 1;
            if (oFull) n_full <= n_full + 1;
            if (oDone) n_done <= n_done + 1;
            if (oRst) n_rst <= n_rst + 1;
            if (oWrreq && oRdreq) n_overlap <= n_overlap + 1;
            // Read address must be zero except during c0..c3 of a rectangle.
            if (!oRdreq && addr_pos == 0 && oAddr_read != 10'd0) n_stray <= n_stray + 1;
            if (oRdreq) addr_pos <= 1;
            else if (addr_pos == 3) addr_pos <= 0;
            else if (addr_pos != 0) addr_pos <= addr_pos + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // iStart pulse, oRst pulse, then the whole window of words.
    task automatic start_and_load(input int w, input bit directed);
        int idx, n, bad;
        exp_words.delete();
        wr_log.delete();
        for (int i = 0; i < N_WORDS; i++)
            exp_words.push_back(directed ? 21'(i) : 21'($urandom));
        @(posedge iClk); #1; iStart = 1'b1;
        @(negedge iClk);
        check($sformatf("w%0d idle_no_rst", w), oRst, 1'b0);
        @(posedge iClk); #1; iStart = 1'b0;
        @(negedge iClk);
        check($sformatf("w%0d rst_pulse", w), oRst, 1'b1);
        check($sformatf("w%0d ready_in_rst", w), oReady, 1'b0);
        idx = 0;
        n = 0;
        while (idx < N_WORDS && n < 5000) begin
            @(posedge iClk); #1;
            iValid = directed ? (n % 2 == 0) : ($urandom_range(0, 3) != 0);
            iStart = directed ? 1'b0 : ($urandom_range(0, 15) == 0);
            iData  = exp_words[idx];
            @(negedge iClk);
            n++;
            if (iValid && oReady) idx++;
        end
        check($sformatf("w%0d load_words_taken", w), idx, N_WORDS);
        // One extra word offered right after the window is complete.
        @(posedge iClk); #1; iStart = 1'b0; iValid = 1'b1; iData = 21'h1ABCDE;
        @(negedge iClk);
        check($sformatf("w%0d ready_after_last", w), oReady, 1'b0);
        check($sformatf("w%0d no_extra_write", w), oWrreq, 1'b0);
        @(posedge iClk); #1; iValid = 1'b0;
        check($sformatf("w%0d write_count", w), wr_log.size(), N_WORDS);
        bad = 0;
        for (int i = 0; i < N_WORDS; i++)
            if (i >= wr_log.size() || wr_log[i] !== exp_words[i]) bad++;
        check($sformatf("w%0d write_data_bad", w), bad, 0);
        $display("load  w%0d: %0d words in %0d cycles, %0d written", w, idx, n, wr_log.size());
    endtask

    // One rectangle: waits for c0, then follows c1..c3.
    task automatic issue_rect(input string tag, input logic [39:0] corners, input bit last,
                              input bit stall, input int prev_rd, output int rd_at);
        int n;
        logic [9:0] c [4];
        for (int k = 0; k < 4; k++) c[k] = corners[k*10 +: 10];
        n = 0;
        do begin
            @(posedge iClk); #1;
            iCorners    = corners;
            iFeat_last  = last;
            iFeat_valid = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
            @(negedge iClk);
            n++;
        end while (!oRdreq && n < 200);
        rd_at = cyc;
        check({tag, " rdreq"}, oRdreq, 1'b1);
        check({tag, " addr_c0"}, oAddr_read, c[0]);
        check({tag, " ack_c0"}, oCorner_ack, 1'b0);
        if (prev_rd >= 0) begin
            if (stall) check({tag, " gap_min"}, (rd_at - prev_rd) >= RD_GAP, 1'b1);
            else       check({tag, " gap_exact"}, rd_at - prev_rd, RD_GAP);
        end
        for (int k = 1; k < 4; k++) begin
            @(posedge iClk); #1;
            if (stall) iFeat_valid = $urandom_range(0, 1);
            @(negedge iClk);
            check($sformatf("%s addr_c%0d", tag, k), oAddr_read, c[k]);
            check($sformatf("%s rdreq_c%0d", tag, k), oRdreq, 1'b0);
            check($sformatf("%s ack_c%0d", tag, k), oCorner_ack, (k == 3));
        end
        $display("rect  %s: rd@%0d addr %0d %0d %0d %0d last=%0d", tag, rd_at,
                 c[0], c[1], c[2], c[3], last);
    endtask

    // Handoff after the 8th rectangle, then clear (and done if last).
    task automatic handoff(input string tag, input int delay, input bit last);
        int n;
        bit held, rd_seen;
        n = 0;
        rd_seen = 0;
        do begin
            @(posedge iClk); #1;
            iFeat_valid = 1'b0;
            iWin_ack    = (delay == 0);
            @(negedge iClk);
            n++;
            if (oRdreq) rd_seen = 1;
        end while (!oWin_valid && n < 60);
        // Last c0 at t, c3 at t+3, handoff once RD_GAP cycles have passed: t+8.
        check({tag, " handoff_latency"}, n, 5);
        held = 1;
        for (int k = 1; k <= delay; k++) begin
            @(posedge iClk); #1;
            iWin_ack = (k == delay);
            @(negedge iClk);
            if (!oWin_valid || oFull) held = 0;
            if (oRdreq) rd_seen = 1;
        end
        check({tag, " win_valid_held"}, held, 1'b1);
        check({tag, " no_read_in_hold"}, rd_seen, 1'b0);
        @(posedge iClk); #1; iWin_ack = 1'b0;
        @(negedge iClk);
        check({tag, " full_pulse"}, oFull, 1'b1);
        check({tag, " win_valid_drop"}, oWin_valid, 1'b0);
        check({tag, " no_done_in_clear"}, oDone, 1'b0);
        @(posedge iClk); #1;
        @(negedge iClk);
        check({tag, " full_one_cycle"}, oFull, 1'b0);
        check({tag, " done"}, oDone, last);
        if (last) begin
            @(posedge iClk); #1;
            @(negedge iClk);
            check({tag, " done_one_cycle"}, oDone, 1'b0);
            check({tag, " idle_ready"}, oReady, 1'b0);
        end
        $display("hand  %s: ack delay %0d, last=%0d", tag, delay, last);
    endtask

    task automatic run_window(input int w, input int nfeat, input bit directed, input int first_delay);
        int b_rd, b_full, b_done, b_rst, prev, rd_at;
        bit plain;
        logic [39:0] cr;
        @(posedge iClk); #1;
        b_rd = n_rd; b_full = n_full; b_done = n_done; b_rst = n_rst;
        start_and_load(w, directed);
        for (int f = 0; f < nfeat; f++) begin
            plain = directed && (f == 0);
            prev = -1;
            for (int r = 0; r < N_RECT; r++) begin
                if (plain) begin
                    cr = {10'(3 + 16*r), 10'(2 + 16*r), 10'(1 + 16*r), 10'(16*r)};
                end else begin
                    cr[31:0]  = $urandom;
                    cr[39:32] = 8'($urandom);
                end
                issue_rect($sformatf("w%0d f%0d r%0d", w, f, r), cr, (f == nfeat - 1),
                           !plain, prev, rd_at);
                prev = rd_at;
            end
            handoff($sformatf("w%0d f%0d", w, f),
                    (f == 0) ? first_delay : $urandom_range(0, 4), (f == nfeat - 1));
        end
        @(posedge iClk); #1;
        check($sformatf("w%0d rdreq_total", w), n_rd - b_rd, nfeat * N_RECT);
        check($sformatf("w%0d full_total", w), n_full - b_full, nfeat);
        check($sformatf("w%0d done_total", w), n_done - b_done, 1);
        check($sformatf("w%0d rst_total", w), n_rst - b_rst, 1);
        check($sformatf("w%0d rd_wr_overlap", w), n_overlap, 0);
        check($sformatf("w%0d stray_addr", w), n_stray, 0);
        $display("win   w%0d: %0d features done", w, nfeat);
    endtask

    initial begin
        int n, rd_at;
        logic [39:0] cr;

        // Reset held with iStart high: everything stays quiet.
        iReset_n = 1'b0;
        iStart   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge iClk); #1;
            @(negedge iClk);
            check($sformatf("reset_outputs_%0d", i), outs_all, '0);
        end
        @(posedge iClk); #1; iReset_n = 1'b1; iStart = 1'b0;
        @(negedge iClk);
        check("idle_after_release", outs_all, '0);
        $display("reset: released at cycle %0d", cyc);

        // Directed window: counting data, toggling valid, patterned corners,
        // classifier ack delayed 10 cycles.
        run_window(0, 1, 1'b1, 10);

        // Three features, random data/corners/stalls, ack in the rising cycle.
        run_window(1, 3, 1'b0, 0);

        // Reset while the second rectangle is being issued.
        start_and_load(2, 1'b0);
        cr[31:0] = $urandom; cr[39:32] = 8'($urandom);
        issue_rect("w2 f0 r0", cr, 1'b0, 1'b0, -1, rd_at);
        cr[31:0] = $urandom; cr[39:32] = 8'($urandom);
        n = 0;
        do begin
            @(posedge iClk); #1;
            iCorners = cr; iFeat_valid = 1'b1;
            @(negedge iClk);
            n++;
        end while (!oRdreq && n < 50);
        check("abort_second_rdreq", oRdreq, 1'b1);
        @(posedge iClk); #1; iReset_n = 1'b0; iFeat_valid = 1'b0;
        @(negedge iClk);
        @(posedge iClk); #1; iReset_n = 1'b1;
        @(negedge iClk);
        check("abort_idle_outputs", outs_all, '0);
        check("abort_rdreq", oRdreq, 1'b0);
        check("abort_addr", oAddr_read, 10'd0);
        $display("abort w2: reset after second read at cycle %0d", cyc);

        // A fresh window after the abort runs cleanly.
        run_window(3, 2, 1'b0, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
